vdac_out_ctrl: RTL and testbench
================================

Name: vdac_out_ctrl

Overview:
Parametrised composite-video DAC output stage. It replaces the fixed 4-bit, pass-through DAC register path between the video generator and the pad drivers. It adds:
- configurable input and DAC widths;
- a register-programmable source mux (pass, test ramp, constant level, mute);
- offset with saturation;
- sync-level override;
- an underrun counter.

Host access uses the existing sel_ctl/we/addr/din control-bus style. The output feeds the pad output registers clocked by the same clock.

Parameters:
IN_WIDTH, 8, width of sample_in from the video generator
DAC_WIDTH, 4, width of dac_out (1..IN_WIDTH)
SYNC_LEVEL, 0, DAC code forced during sync (DAC_WIDTH bits)
BLANK_LEVEL, 5, DAC code output on underrun in pass mode

Ports:
clk  in  1  pixel/DAC clock (the 2x video clock at top level)
reset  in  1  synchronous, active-high reset
sample_in  in  IN_WIDTH  composite sample from video generator
sample_valid  in  1  sample_in valid this cycle
sync_active  in  1  video generator is in a sync interval
sel_ctl  in  1  control-register select
we  in  1  write strobe; write occurs when sel_ctl&&we
addr  in  2  register address
din  in  8  write data
ctl_dout  out  8  read data; combinational from addr when sel_ctl=1, else 0
dac_out  out  DAC_WIDTH  registered DAC code
dac_oe  out  1  registered output enable

Behaviour:
- Reset values:
  - CTRL = 0: mode pass, enable 0.
  - LEVEL = 0, OFFSET = 0, UNDERRUN = 0.
  - Ramp counter 0.
  - All pipeline registers 0; dac_out = 0; dac_oe = 0.
  - Reset is honoured mid-pipeline: every stage clears in the same cycle.
- Registers:
  - addr0 CTRL: bit0 enable, bits2:1 mode (0 pass, 1 ramp, 2 level, 3 mute).
  - addr1 LEVEL: constant code, IN_WIDTH domain, low 8 bits.
  - addr2 OFFSET: signed 8-bit, added in IN_WIDTH domain with sign extension.
  - addr3 UNDERRUN: read-only saturating 8-bit count; any write to addr3 clears it.
  - A write takes effect on the next clock edge.
- Pipeline, fixed latency 3 cycles from input to dac_out; sync_active and enable are delayed alongside the data:
  - S1 source select:
    - pass: sample_valid ? sample_in : BLANK_LEVEL left-aligned to IN_WIDTH.
    - ramp: ramp counter, incremented every cycle while enable=1, wrapping at 2^IN_WIDTH-1 -> 0.
    - level: LEVEL.
    - mute: 0.
  - S2 offset: signed add in IN_WIDTH+2 bits, saturate to [0, 2^IN_WIDTH-1].
  - S3 reduce: dac_out = top DAC_WIDTH bits of S2 (truncate).
  - S3 sync override: if the delayed sync_active=1 and mode != mute, dac_out = SYNC_LEVEL.
  - S3 enable: if the delayed enable=0, dac_out = 0.
- dac_oe equals enable delayed 3 cycles.
- Underrun: increments when mode=pass, enable=1, sample_valid=0 and sync_active=0. It saturates at 255. If a clear write and an underrun event fall in the same cycle, the clear wins and the result is 0.
- A mode change mid-line takes effect at S1 on the cycle after the write; no glitch suppression.
- The ramp counter holds its value when enable=0 and resets only on reset.

Optional Feature:
VDAC_DITHER_EN:
- Defined: a 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle. Its low (IN_WIDTH-DAC_WIDTH) bits are added to the S2 value before truncation, with saturation at full-scale. Sync and enable overrides are unaffected. Latency stays 3.
- Undefined: plain truncation; no LFSR logic.

Decomposition:
- Package vdac_pkg:
  - mode encodings (MODE_PASS, MODE_RAMP, MODE_LEVEL, MODE_MUTE);
  - register addresses (REG_CTRL..REG_UNDERRUN);
  - CTRL bit positions;
  - LFSR seed and taps.
- One sub-module, vdac_lfsr: the dither LFSR, instantiated only under VDAC_DITHER_EN.

Test Plan:
- Reset then enable=1, mode pass, sample_valid=1, sample_in=8'hA0, OFFSET=0 -> dac_out=4'hA exactly 3 cycles after the input; dac_oe=1 three cycles after the enable write.
- OFFSET=8'h7F with sample_in=8'hF0 -> dac_out=4'hF (saturated high); OFFSET=8'h80 (-128) with sample_in=8'h10 -> dac_out=0 (saturated low).
- Mode pass, 300 cycles with sample_valid=0 and sync_active=0 -> dac_out=BLANK_LEVEL top bits; UNDERRUN reads 255; a write to addr3 coincident with an underrun reads 0 next cycle.
- Mode ramp, enable=1 for 512 cycles -> the S1 value wraps 255 -> 0 at cycle 256; dac_out steps 0..F, each value held 16 cycles.
- sync_active=1 in modes pass, ramp and level -> dac_out=SYNC_LEVEL; in mute -> 0.
- Assert reset mid-stream with a nonzero pipeline -> dac_out=0, dac_oe=0, all registers 0 on the next cycle; with VDAC_DITHER_EN defined, the LFSR reloads 16'hACE1.

Source files
------------

// File: rtl/vdac_pkg.sv
// Shared definitions for the composite-video DAC output stage.
// Contents: mode encodings, register map, CTRL field positions, side-band
// pipeline payload, and the dither LFSR seed/taps with its step function.
package vdac_pkg;

    // Source selection for pipeline stage 1
    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_RAMP  = 2'd1,
        MODE_LEVEL = 2'd2,
        MODE_MUTE  = 2'd3
    } vdac_mode_e;

    // Host register map
    typedef enum logic [1:0] {
        REG_CTRL     = 2'd0,
        REG_LEVEL    = 2'd1,
        REG_OFFSET   = 2'd2,
        REG_UNDERRUN = 2'd3
    } vdac_reg_e;

    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_MODE_LSB = 1;
    localparam int unsigned CTRL_MODE_MSB = 2;

    // CTRL register contents; packed order matches the bit positions above
    typedef struct packed {
        vdac_mode_e mode;
        logic       en;
    } vdac_ctrl_t;

    // Control flags travelling down the pipeline alongside the sample
    typedef struct packed {
        logic en;
        logic sync;
        logic mute;
    } vdac_side_t;

    // Galois LFSR, taps 16,14,13,11 (right-shifting form)
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/vdac_lfsr.sv
// Dither source: free-running 16-bit Galois LFSR, advances every clock.
// Only compiled when VDAC_DITHER_EN is defined.
// Ports:
//   clk   - pixel/DAC clock
//   reset - synchronous active-high reset, reloads LFSR_SEED
//   lfsr  - current LFSR state
`ifdef VDAC_DITHER_EN
module vdac_lfsr
    import vdac_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] lfsr
);

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

endmodule
`endif

// File: rtl/vdac_out_ctrl.sv
// Composite-video DAC output stage: source mux, signed offset with
// saturation, width reduction, sync/enable overrides and underrun counter.
// Fixed 3-cycle latency from sample_in to dac_out.
// Optional dither (macro VDAC_DITHER_EN): LFSR noise added before truncation.
// Ports:
//   clk          - pixel/DAC clock
//   reset        - synchronous active-high reset
//   sample_in    - composite sample from the video generator
//   sample_valid - sample_in valid this cycle
//   sync_active  - generator is in a sync interval
//   sel_ctl, we, addr, din - host control bus (write when sel_ctl && we)
//   ctl_dout     - combinational read data, 0 when sel_ctl=0
//   dac_out      - registered DAC code
//   dac_oe       - registered output enable
module vdac_out_ctrl
    import vdac_pkg::*;
#(
    parameter int unsigned              IN_WIDTH    = 8,
    parameter int unsigned              DAC_WIDTH   = 4,
    parameter logic [DAC_WIDTH-1:0]     SYNC_LEVEL  = '0,
    parameter logic [DAC_WIDTH-1:0]     BLANK_LEVEL = DAC_WIDTH'(5)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IN_WIDTH-1:0]  sample_in,
    input  logic                 sample_valid,
    input  logic                 sync_active,
    input  logic                 sel_ctl,
    input  logic                 we,
    input  logic [1:0]           addr,
    input  logic [7:0]           din,
    output logic [7:0]           ctl_dout,
    output logic [DAC_WIDTH-1:0] dac_out,
    output logic                 dac_oe
);

    localparam int unsigned DROP_W = IN_WIDTH - DAC_WIDTH;
    // Wide enough for the unsigned sample plus a sign-extended 8-bit offset
    localparam int unsigned SUM_W  = ((IN_WIDTH > 8) ? IN_WIDTH : 8) + 2;
    localparam logic [IN_WIDTH-1:0] BLANK_ALIGNED = IN_WIDTH'(BLANK_LEVEL) << DROP_W;

    vdac_ctrl_t          ctrl_q;
    logic [7:0]          level_q;
    logic [7:0]          offset_q;
    logic [7:0]          underrun_q;
    logic [IN_WIDTH-1:0] ramp_q;

    logic [IN_WIDTH-1:0] s1_d, s1_q;
    logic [IN_WIDTH-1:0] s2_d, s2_q;
    logic [SUM_W-1:0]    s2_sum;
    logic [IN_WIDTH-1:0] s3_full;
    logic [DAC_WIDTH-1:0] s3_code;
    vdac_side_t          side_s1, side_s2;

    logic wr_en;
    logic ur_event;
    logic ur_clear;

    assign wr_en    = sel_ctl && we;
    assign ur_clear = wr_en && (vdac_reg_e'(addr) == REG_UNDERRUN);
    assign ur_event = ctrl_q.en && (ctrl_q.mode == MODE_PASS) && !sample_valid && !sync_active;

    // Host register writes
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q   <= '0;
            level_q  <= '0;
            offset_q <= '0;
        end else if (wr_en) begin
            case (vdac_reg_e'(addr))
                REG_CTRL: begin
                    ctrl_q.en   <= din[CTRL_EN_BIT];
                    ctrl_q.mode <= vdac_mode_e'(din[CTRL_MODE_MSB:CTRL_MODE_LSB]);
                end
                REG_LEVEL:  level_q  <= din;
                REG_OFFSET: offset_q <= din;
                default: ;
            endcase
        end
    end

    // Saturating underrun counter; a clear write wins over a same-cycle event
    always_ff @(posedge clk) begin
        if (reset || ur_clear) begin
            underrun_q <= '0;
        end else if (ur_event && (underrun_q != 8'hFF)) begin
            underrun_q <= underrun_q + 8'd1;
        end
    end

    // Ramp runs whenever enabled, independent of the selected mode
    always_ff @(posedge clk) begin
        if (reset) begin
            ramp_q <= '0;
        end else if (ctrl_q.en) begin
            ramp_q <= ramp_q + IN_WIDTH'(1);
        end
    end

    // Host read mux
    always_comb begin
        ctl_dout = '0;
        if (sel_ctl) begin
            case (vdac_reg_e'(addr))
                REG_CTRL:     ctl_dout = {5'b0, ctrl_q};
                REG_LEVEL:    ctl_dout = level_q;
                REG_OFFSET:   ctl_dout = offset_q;
                REG_UNDERRUN: ctl_dout = underrun_q;
                default:      ctl_dout = '0;
            endcase
        end
    end

    // S1 source select
    always_comb begin
        s1_d = '0;
        case (ctrl_q.mode)
            MODE_PASS:  s1_d = sample_valid ? sample_in : BLANK_ALIGNED;
            MODE_RAMP:  s1_d = ramp_q;
            MODE_LEVEL: s1_d = IN_WIDTH'(level_q);
            default:    s1_d = '0;
        endcase
    end

    // S2 signed offset, clamped to [0, full-scale]
    always_comb begin
        s2_sum = {{(SUM_W-IN_WIDTH){1'b0}}, s1_q} + {{(SUM_W-8){offset_q[7]}}, offset_q};
        if (s2_sum[SUM_W-1]) begin
            s2_d = '0;
        end else if (|s2_sum[SUM_W-2:IN_WIDTH]) begin
            s2_d = '1;
        end else begin
            s2_d = s2_sum[IN_WIDTH-1:0];
        end
    end

`ifdef VDAC_DITHER_EN
    localparam int unsigned DITH_W    = IN_WIDTH + 1;
    localparam logic [15:0] DITH_MASK = 16'((33'd1 << DROP_W) - 33'd1);

    logic [15:0]       lfsr;
    logic [DITH_W-1:0] dith_sum;

    vdac_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .lfsr  (lfsr)
    );

    // Dither below the retained bits, saturating at full-scale
    always_comb begin
        dith_sum = {1'b0, s2_q} + DITH_W'(lfsr & DITH_MASK);
        s3_full  = dith_sum[IN_WIDTH] ? '1 : dith_sum[IN_WIDTH-1:0];
    end
`else
    assign s3_full = s2_q;
`endif

    assign s3_code = s3_full[IN_WIDTH-1 -: DAC_WIDTH];

    // Pipeline stages; reset clears every stage in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            side_s1 <= '0;
            side_s2 <= '0;
            dac_out <= '0;
            dac_oe  <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            side_s1.en   <= ctrl_q.en;
            side_s1.sync <= sync_active;
            side_s1.mute <= (ctrl_q.mode == MODE_MUTE);
            s2_q         <= s2_d;
            side_s2      <= side_s1;
            dac_oe       <= side_s2.en;
            if (!side_s2.en) begin
                dac_out <= '0;
            end else if (side_s2.sync && !side_s2.mute) begin
                dac_out <= SYNC_LEVEL;
            end else begin
                dac_out <= s3_code;
            end
        end
    end

endmodule

// File: tb/tb_vdac_out_ctrl.sv
// Directed self-checking bench for vdac_out_ctrl (default build, no dither).
// SYNC_LEVEL is overridden to 3 so sync output is distinguishable from 0.
module tb_vdac_out_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       sync_active;
    logic       sel_ctl;
    logic       we;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] ctl_dout;
    logic [3:0] dac_out;
    logic       dac_oe;

    int total;
    int bad;

    vdac_out_ctrl #(
        .IN_WIDTH    (8),
        .DAC_WIDTH   (4),
        .SYNC_LEVEL  (4'h3),
        .BLANK_LEVEL (4'h5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sync_active  (sync_active),
        .sel_ctl      (sel_ctl),
        .we           (we),
        .addr         (addr),
        .din          (din),
        .ctl_dout     (ctl_dout),
        .dac_out      (dac_out),
        .dac_oe       (dac_oe)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        sel_ctl = 1'b1;
        we      = 1'b1;
        addr    = a;
        din     = d;
        @(posedge clk);
        #1;
        sel_ctl = 1'b0;
        we      = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [1:0] a, input logic [7:0] exp);
        sel_ctl = 1'b1;
        we      = 1'b0;
        addr    = a;
        #1;
        check(tag, 32'(ctl_dout), 32'(exp));
        sel_ctl = 1'b0;
    endtask

    task automatic dac_check(input string tag, input logic [3:0] exp);
        check(tag, 32'(dac_out), 32'(exp));
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        sample_in    = 8'h00;
        sample_valid = 1'b0;
        sync_active  = 1'b0;
        sel_ctl      = 1'b0;
        we           = 1'b0;
        addr         = 2'd0;
        din          = 8'h00;
        tick(3);
        reset = 1'b0;

        // Reset state
        dac_check("rst_dac", 4'h0);
        check("rst_oe", 32'(dac_oe), 32'd0);
        rd_check("rst_ctrl", 2'd0, 8'h00);
        rd_check("rst_level", 2'd1, 8'h00);
        rd_check("rst_offset", 2'd2, 8'h00);

        // Pass mode: enable write at edge E, oe/data appear at E+3
        sample_in    = 8'hA0;
        sample_valid = 1'b1;
        wr(2'd0, 8'h01);
        tick(2);
        check("oe_e2", 32'(dac_oe), 32'd0);
        dac_check("dac_e2", 4'h0);
        tick(1);
        check("oe_e3", 32'(dac_oe), 32'd1);
        dac_check("pass_a0", 4'hA);
        rd_check("ctrl_rb", 2'd0, 8'h01);

        // Latency: new sample lands exactly three edges later
        sample_in = 8'h30;
        tick(2);
        dac_check("lat_2", 4'hA);
        tick(1);
        dac_check("lat_3", 4'h3);

        // Offset and saturation
        sample_in = 8'hF0;
        wr(2'd2, 8'h7F);
        tick(4);
        dac_check("sat_high", 4'hF);
        sample_in = 8'h10;
        wr(2'd2, 8'h80);
        tick(4);
        dac_check("sat_low", 4'h0);
        rd_check("offset_rb", 2'd2, 8'h80);
        sample_in = 8'h50;
        wr(2'd2, 8'hF0);
        tick(4);
        dac_check("off_neg", 4'h4);
        sample_in = 8'hA0;
        wr(2'd2, 8'h10);
        tick(4);
        dac_check("off_pos", 4'hB);
        wr(2'd2, 8'h00);

        // Underrun counting and clear priority
        sample_valid = 1'b0;
        wr(2'd3, 8'h00);
        rd_check("ur_clr0", 2'd3, 8'h00);
        tick(10);
        rd_check("ur_10", 2'd3, 8'd10);
        tick(300);
        dac_check("blank", 4'h5);
        rd_check("ur_sat", 2'd3, 8'hFF);
        wr(2'd3, 8'h00);
        rd_check("ur_clr_win", 2'd3, 8'h00);

        // Sync override in each mode
        sync_active = 1'b1;
        tick(5);
        rd_check("ur_sync", 2'd3, 8'h00);
        dac_check("sync_pass", 4'h3);
        wr(2'd0, 8'h03);
        tick(4);
        dac_check("sync_ramp", 4'h3);
        wr(2'd1, 8'hC4);
        wr(2'd0, 8'h05);
        sync_active = 1'b0;
        tick(4);
        dac_check("level", 4'hC);
        addr = 2'd1;
        #1;
        check("dout_unsel", 32'(ctl_dout), 32'd0);
        sync_active = 1'b1;
        tick(4);
        dac_check("sync_level", 4'h3);
        wr(2'd0, 8'h07);
        tick(4);
        dac_check("sync_mute", 4'h0);
        check("oe_mute", 32'(dac_oe), 32'd1);
        sync_active = 1'b0;
        wr(2'd0, 8'h04);
        tick(4);
        dac_check("dis_dac", 4'h0);
        check("dis_oe", 32'(dac_oe), 32'd0);

        // Build nonzero state, then reset mid-stream
        wr(2'd0, 8'h01);
        tick(5);
        rd_check("ur_pass5", 2'd3, 8'd5);
        wr(2'd0, 8'h05);
        wr(2'd2, 8'h10);
        tick(4);
        dac_check("lvl_off", 4'hD);
        reset = 1'b1;
        tick(1);
        dac_check("mid_rst_dac", 4'h0);
        check("mid_rst_oe", 32'(dac_oe), 32'd0);
        rd_check("mid_rst_ctrl", 2'd0, 8'h00);
        rd_check("mid_rst_level", 2'd1, 8'h00);
        rd_check("mid_rst_off", 2'd2, 8'h00);
        reset = 1'b0;
        rd_check("mid_rst_ur", 2'd3, 8'h00);
        tick(1);
        dac_check("post_rst_dac", 4'h0);

        // Ramp from a freshly reset counter: output at edge E+m is (m-3) mod 256
        wr(2'd0, 8'h03);
        for (int m = 1; m <= 514; m++) begin
            tick(1);
            if (m >= 3) begin
                check("ramp", 32'(dac_out), 32'(((m - 3) % 256) / 16));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
